cdc_hs_rx: RTL and testbench

Responder end of a 4-phase req/ack handshake used to move a multi-bit word into this block's clock domain.
- Synchronizes an asynchronous level request from the initiator's domain.
- Captures the stable data word and presents it downstream on a valid/ready interface.
- Returns a registered level acknowledge.
- Sits in the receiving domain, paired with an initiator in the source domain that holds data_i stable while req_i is high.

---
 rtl/cdc_hs_rx.sv | 57 +++++
 tb/tb_cdc_hs_rx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cdc_hs_rx.sv
// cdc_hs_rx: 4-phase req/ack responder that captures a word and delivers it on valid/ready
module cdc_hs_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              err_o,
  input  logic              err_clr_i,
  output logic [CNT_W-1:0]  xfer_cnt_o
);
  typedef enum logic [1:0] {IDLE, HOLD, WAIT_LOW} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic req_s;
  assign req_s = sync[SYNC_STAGES-1];
  always_ff @(posedge clk)
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], req_i};
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ack_o      <= 1'b0;
      valid_o    <= 1'b0;
      data_o     <= '0;
      err_o      <= 1'b0;
      xfer_cnt_o <= '0;
    end else begin
      err_o <= (state == HOLD && !req_s) | (err_o & ~err_clr_i);
      case (state)
        IDLE: if (req_s) begin
          data_o  <= data_i;
          valid_o <= 1'b1;
          state   <= HOLD;
        end
        HOLD: if (ready_i) begin
          valid_o    <= 1'b0;
          ack_o      <= 1'b1;
          xfer_cnt_o <= xfer_cnt_o + 1'b1;
          state      <= WAIT_LOW;
        end
        WAIT_LOW: if (!req_s) begin
          ack_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cdc_hs_rx.sv
// tb_cdc_hs_rx: directed handshake scenarios checked against a transfer-level model and scoreboard
module tb_cdc_hs_rx;
  localparam int SS = 2;
  logic clk = 0, rst = 1, req_i = 0, ready_i = 0, err_clr_i = 0;
  logic [7:0] data_i = 0;
  logic ack_o, valid_o, err_o;
  logic [7:0] data_o;
  logic [15:0] xfer_cnt_o;
  logic ack_w, valid_w, err_w;
  logic [7:0] data_w;
  logic [1:0] cnt_w;
  int n_chk = 0, n_pass = 0, rises = 0, base;
  logic [7:0] exp_q[$];
  logic [3:0] m_hist;
  logic m_valid, m_ack, m_err, prev_valid = 0;
  logic [7:0] m_data;
  logic [15:0] m_cnt;
  logic [1:0] seq [5];
  always #5 clk = ~clk;
  cdc_hs_rx #(.DATA_W(8), .SYNC_STAGES(SS), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .data_i(data_i), .ack_o(ack_o), .data_o(data_o),
    .valid_o(valid_o), .ready_i(ready_i), .err_o(err_o), .err_clr_i(err_clr_i), .xfer_cnt_o(xfer_cnt_o));
  cdc_hs_rx #(.DATA_W(8), .SYNC_STAGES(SS), .CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .req_i(req_i), .data_i(data_i), .ack_o(ack_w), .data_o(data_w),
    .valid_o(valid_w), .ready_i(ready_i), .err_o(err_w), .err_clr_i(err_clr_i), .xfer_cnt_o(cnt_w));
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_for(input bit ack_sel, input logic lvl, input string nm);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk);
      #1;
      ok = ((ack_sel ? ack_o : valid_o) === lvl);
    end
    check(nm, 32'(ok), 1);
  endtask
  task automatic do_reset();
    req_i = 0;
    ready_i = 0;
    rst = 1;
    tick(2);
    rst = 0;
  endtask
  // Transfer-level model: a word is pending, acknowledged, or neither; req is seen SS edges late.
  always @(posedge clk) begin
    logic rs, set;
    if (!rst && valid_o && ready_i) begin
      if (exp_q.size() == 0) check("sb_extra", 1, 0);
      else check("sb_data", data_o, exp_q.pop_front());
    end
    rs = m_hist[SS-1];
    if (rst) begin
      m_hist = 0; m_valid = 0; m_ack = 0; m_err = 0; m_data = 0; m_cnt = 0;
    end else begin
      set = m_valid && !rs;
      if (m_valid) begin
        if (ready_i) begin
          m_valid = 0;
          m_ack = 1;
          m_cnt++;
        end
      end else if (m_ack) begin
        if (!rs) m_ack = 0;
      end else if (rs) begin
        m_data = data_i;
        m_valid = 1;
      end
      m_err = set | (m_err & !err_clr_i);
      m_hist = {m_hist[2:0], req_i};
    end
    #1;
    if (valid_o && !prev_valid) rises++;
    prev_valid = valid_o;
    check("cyc_valid", valid_o, m_valid);
    check("cyc_ack", ack_o, m_ack);
    check("cyc_err", err_o, m_err);
    check("cyc_data", data_o, m_data);
    check("cyc_cnt", xfer_cnt_o, m_cnt);
    check("cyc_cnt_w", cnt_w, m_cnt[1:0]);
    check("cyc_valid_w", valid_w, m_valid);
    check("cyc_ack_w", ack_w, m_ack);
    check("cyc_err_w", err_w, m_err);
    check("cyc_data_w", data_w, m_data);
  end
  initial begin
    seq[0] = 1; seq[1] = 2; seq[2] = 3; seq[3] = 0; seq[4] = 1;
    tick(2);
    check("rst_valid", valid_o, 0);
    check("rst_ack", ack_o, 0);
    check("rst_err", err_o, 0);
    check("rst_data", data_o, 0);
    check("rst_cnt", xfer_cnt_o, 0);
    rst = 0;
    // single transfer with ready tied high
    ready_i = 1; data_i = 8'hA5; req_i = 1; exp_q.push_back(8'hA5);
    tick(2);
    check("t1_not_yet", valid_o, 0);
    tick(1);
    check("t1_valid", valid_o, 1);
    check("t1_data", data_o, 8'hA5);
    check("t1_ack_low", ack_o, 0);
    tick(1);
    check("t1_valid_drop", valid_o, 0);
    check("t1_ack_rise", ack_o, 1);
    check("t1_cnt", xfer_cnt_o, 1);
    req_i = 0;
    tick(2);
    check("t1_ack_hold", ack_o, 1);
    tick(1);
    check("t1_ack_fall", ack_o, 0);
    // backpressure
    do_reset();
    data_i = 8'h3C; req_i = 1; exp_q.push_back(8'h3C);
    wait_for(0, 1, "t2_valid_wait");
    repeat (10) begin
      tick(1);
      check("t2_data", data_o, 8'h3C);
      check("t2_ack", ack_o, 0);
      check("t2_valid", valid_o, 1);
    end
    ready_i = 1;
    tick(1);
    check("t2_accept_valid", valid_o, 0);
    check("t2_accept_ack", ack_o, 1);
    req_i = 0;
    wait_for(1, 0, "t2_ack_low_wait");
    // back-to-back
    do_reset();
    ready_i = 1;
    base = rises;
    for (int i = 1; i <= 4; i++) begin
      data_i = 8'(i); req_i = 1; exp_q.push_back(8'(i));
      wait_for(1, 1, "t3_ack_high_wait");
      req_i = 0;
      wait_for(1, 0, "t3_ack_low_wait");
    end
    check("t3_pulses", rises - base, 4);
    check("t3_cnt", xfer_cnt_o, 4);
    check("t3_sb_empty", exp_q.size(), 0);
    // protocol error: req drops while holding
    do_reset();
    data_i = 8'h5A; req_i = 1; exp_q.push_back(8'h5A);
    wait_for(0, 1, "t4_valid_wait");
    req_i = 0;
    tick(2);
    check("t4_err_early", err_o, 0);
    tick(1);
    check("t4_err_set", err_o, 1);
    err_clr_i = 1;
    tick(2);
    check("t4_set_wins", err_o, 1);
    err_clr_i = 0; ready_i = 1;
    tick(1);
    check("t4_accept_valid", valid_o, 0);
    check("t4_ack_rise", ack_o, 1);
    tick(1);
    check("t4_ack_one_cycle", ack_o, 0);
    err_clr_i = 1;
    tick(1);
    check("t4_err_clr", err_o, 0);
    err_clr_i = 0; ready_i = 0;
    // reset in the middle of a hold, req stays high
    do_reset();
    data_i = 8'h77; req_i = 1; exp_q.push_back(8'h77);
    wait_for(0, 1, "t5_valid_wait");
    rst = 1;
    tick(1);
    check("t5_rst_valid", valid_o, 0);
    check("t5_rst_ack", ack_o, 0);
    check("t5_rst_cnt", xfer_cnt_o, 0);
    rst = 0;
    tick(2);
    check("t5_not_yet", valid_o, 0);
    tick(1);
    check("t5_recapture", valid_o, 1);
    check("t5_data", data_o, 8'h77);
    ready_i = 1;
    tick(1);
    check("t5_cnt", xfer_cnt_o, 1);
    check("t5_ack", ack_o, 1);
    req_i = 0;
    wait_for(1, 0, "t5_ack_low_wait");
    // counter wrap on the 2-bit instance
    do_reset();
    ready_i = 1;
    for (int i = 0; i < 5; i++) begin
      data_i = 8'h10 + 8'(i); req_i = 1; exp_q.push_back(8'h10 + 8'(i));
      wait_for(1, 1, "t6_ack_high_wait");
      check("t6_cnt_w", cnt_w, seq[i]);
      req_i = 0;
      wait_for(1, 0, "t6_ack_low_wait");
    end
    check("end_sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
